// File: rtl/read_src_fsm.sv
// Source-read engine: pops a descriptor, issues AXI4 INCR read bursts of up to 16 beats
// (one in flight), and pushes every returned R beat into the data FIFO.
module read_src_fsm #(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 64,
    parameter int LENGTH_W     = 20,
    parameter int AXI_LEN_W    = 4,
    parameter int FIFO_CNT_W   = 10,
    parameter int PERF_CNTR_W  = 32,
    parameter bit ENABLE_ERROR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   desc_not_empty,
    input  logic                   desc_go,
    input  logic [ADDR_W-1:0]      desc_src_addr,
    input  logic [LENGTH_W-1:0]    desc_length,
    output logic                   desc_rd_en,
    input  logic                   csr_reset_disp,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    input  logic                   rvalid,
    input  logic                   rlast,
    input  logic [1:0]             rresp,
    input  logic [DATA_W-1:0]      rdata,
    output logic                   rready,
    input  logic [FIFO_CNT_W-1:0]  fifo_space,
    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_wr_data,
    output logic                   rd_fsm_done,
    output logic                   busy,
    output logic                   stopped_on_error,
    output logic                   rd_rsp_err,
    output logic [5:0]             rd_state,
    output logic [PERF_CNTR_W-1:0] clk_cnt,
    output logic [PERF_CNTR_W-1:0] valid_cnt
);

    localparam int MAX_BURST   = 2 ** AXI_LEN_W;
    localparam int BURST_BYTES = MAX_BURST * (DATA_W / 8);
    localparam int AXSIZE      = $clog2(DATA_W / 8);
    localparam int CMP_W       = (FIFO_CNT_W > LENGTH_W) ? FIFO_CNT_W : LENGTH_W;

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        SPACE_WAIT = 6'b000010,
        ADDR       = 6'b000100,
        DATA       = 6'b001000,
        DONE       = 6'b010000,
        ERROR      = 6'b100000
    } state_t;

    state_t                 state_q, state_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   desc_rd_en_q, desc_rd_en_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [2:0]             arsize_q, arsize_d;
    logic [1:0]             arburst_q, arburst_d;
    logic [LENGTH_W-1:0]    remaining_q, remaining_d;
    logic [LENGTH_W-1:0]    burst_q, burst_d;
    logic [LENGTH_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [PERF_CNTR_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [PERF_CNTR_W-1:0] valid_cnt_q, valid_cnt_d;

    logic [LENGTH_W-1:0]    burst_len;
    logic [LENGTH_W-1:0]    rem_after;
    logic                   beat;
    logic                   last_expected;
    logic                   bad_beat;

    assign burst_len     = (remaining_q > LENGTH_W'(MAX_BURST)) ? LENGTH_W'(MAX_BURST) : remaining_q;
    assign rem_after     = remaining_q - burst_q;
    assign beat          = rvalid & rready_q;
    assign last_expected = (beat_cnt_q + LENGTH_W'(1)) == burst_q;
    assign bad_beat      = ENABLE_ERROR && ((rresp != 2'b00) || (rlast != last_expected));

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        desc_rd_en_d = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;
        err_d        = err_q;
        addr_d       = addr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        beat_cnt_d   = beat_cnt_q;
        clk_cnt_d    = clk_cnt_q;
        valid_cnt_d  = valid_cnt_q;

        if (state_q != IDLE && state_q != ERROR) begin
            clk_cnt_d = clk_cnt_q + PERF_CNTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (desc_go && desc_not_empty) begin
                    desc_rd_en_d = 1'b1;
                    addr_d       = desc_src_addr;
                    remaining_d  = desc_length;
                    clk_cnt_d    = '0;
                    valid_cnt_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = (desc_length == '0) ? DONE : SPACE_WAIT;
                end
            end
            SPACE_WAIT: begin
                // Reserve FIFO room for the whole burst so rready never has to back off.
                if (CMP_W'(fifo_space) >= CMP_W'(burst_len)) begin
                    burst_d   = burst_len;
                    arlen_d   = 8'(burst_len - LENGTH_W'(1));
                    arsize_d  = 3'(AXSIZE);
                    arburst_d = 2'b01;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    beat_cnt_d  = beat_cnt_q + LENGTH_W'(1);
                    valid_cnt_d = valid_cnt_q + PERF_CNTR_W'(1);
                    if (bad_beat) begin
                        rready_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ERROR;
                    end else if (rlast) begin
                        rready_d    = 1'b0;
                        remaining_d = rem_after;
                        addr_d      = addr_q + ADDR_W'(BURST_BYTES);
                        state_d     = (rem_after == '0) ? DONE : SPACE_WAIT;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERROR: begin
                if (csr_reset_disp) begin
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            desc_rd_en_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            remaining_q  <= '0;
            burst_q      <= '0;
            beat_cnt_q   <= '0;
            clk_cnt_q    <= '0;
            valid_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            desc_rd_en_q <= desc_rd_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            remaining_q  <= remaining_d;
            burst_q      <= burst_d;
            beat_cnt_q   <= beat_cnt_d;
            clk_cnt_q    <= clk_cnt_d;
            valid_cnt_q  <= valid_cnt_d;
        end
    end

    assign desc_rd_en       = desc_rd_en_q;
    assign arvalid          = arvalid_q;
    assign araddr           = addr_q;
    assign arlen            = arlen_q;
    assign arsize           = arsize_q;
    assign arburst          = arburst_q;
    assign rready           = rready_q;
    assign fifo_wr_en       = beat;
    assign fifo_wr_data     = rdata;
    assign rd_fsm_done      = done_q;
    assign busy             = busy_q;
    assign stopped_on_error = err_q;
    assign rd_rsp_err       = err_q;
    assign rd_state         = state_q;
    assign clk_cnt          = clk_cnt_q;
    assign valid_cnt        = valid_cnt_q;

endmodule

// File: tb/tb_read_src_fsm.sv
// Directed bench for read_src_fsm: a small AXI read responder plus logs of AR requests,
// FIFO pushes and done pulses, compared against hand-computed expectations.
module tb_read_src_fsm;

    localparam int DATA_W      = 512;
    localparam int ADDR_W      = 64;
    localparam int LENGTH_W    = 20;
    localparam int FIFO_CNT_W  = 10;
    localparam int PERF_CNTR_W = 32;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   desc_not_empty = 1'b0;
    logic                   desc_go = 1'b0;
    logic [ADDR_W-1:0]      desc_src_addr = '0;
    logic [LENGTH_W-1:0]    desc_length = '0;
    logic                   desc_rd_en;
    logic                   csr_reset_disp = 1'b0;
    logic                   arvalid;
    logic                   arready = 1'b0;
    logic [ADDR_W-1:0]      araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   rvalid = 1'b0;
    logic                   rlast = 1'b0;
    logic [1:0]             rresp = 2'b00;
    logic [DATA_W-1:0]      rdata = '0;
    logic                   rready;
    logic [FIFO_CNT_W-1:0]  fifo_space = 10'd16;
    logic                   fifo_wr_en;
    logic [DATA_W-1:0]      fifo_wr_data;
    logic                   rd_fsm_done;
    logic                   busy;
    logic                   stopped_on_error;
    logic                   rd_rsp_err;
    logic [5:0]             rd_state;
    logic [PERF_CNTR_W-1:0] clk_cnt;
    logic [PERF_CNTR_W-1:0] valid_cnt;

    always #5 clk = ~clk;

    read_src_fsm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W), .AXI_LEN_W(4),
        .FIFO_CNT_W(FIFO_CNT_W), .PERF_CNTR_W(PERF_CNTR_W), .ENABLE_ERROR(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .desc_not_empty(desc_not_empty), .desc_go(desc_go),
        .desc_src_addr(desc_src_addr), .desc_length(desc_length), .desc_rd_en(desc_rd_en),
        .csr_reset_disp(csr_reset_disp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rdata(rdata), .rready(rready),
        .fifo_space(fifo_space), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .rd_fsm_done(rd_fsm_done), .busy(busy), .stopped_on_error(stopped_on_error),
        .rd_rsp_err(rd_rsp_err), .rd_state(rd_state), .clk_cnt(clk_cnt), .valid_cnt(valid_cnt)
    );

    int compareCount = 0;
    int failCount    = 0;

    logic [63:0] arAddrLog[$];
    int          arLenLog[$];
    logic [63:0] pushLog[$];
    int          doneCount, rdEnCount, firstArCyc, rdEnCyc, doneCyc;
    logic [2:0]  arSizeSeen;
    logic [1:0]  arBurstSeen;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Beats carry their own byte address replicated across all 64-bit lanes; lanes 7 and 0
    // together reconstruct that address.
    function automatic logic [63:0] lanes(input logic [DATA_W-1:0] d);
        return {d[DATA_W-1 -: 32], d[31:0]};
    endfunction

    // Runs one descriptor through the DUT with a one-burst-at-a-time AXI read responder.
    task automatic applyStimulus(input logic [63:0] addr, input int len, input int errBeat,
                                 input int spaceLow, input int arStall, input int stopPushes);
        logic [63:0] sbAddr, pendAddr[$];
        int          sbLen, sbBeat, gBeat, cyc, arWait, pendLen[$];
        bit          active, finished, prevPend;
        logic [56:0] prevAr;
        arAddrLog.delete(); arLenLog.delete(); pushLog.delete();
        doneCount = 0; rdEnCount = 0; firstArCyc = -1; rdEnCyc = -1; doneCyc = -1;
        sbAddr = '0; sbLen = 0; sbBeat = 0; prevAr = '0;
        active = 0; finished = 0; prevPend = 0; gBeat = 0; cyc = 0; arWait = 0;
        desc_src_addr  = addr;
        desc_length    = LENGTH_W'(len);
        desc_go        = 1'b1;
        desc_not_empty = 1'b1;
        while (!finished && cyc < 400) begin
            fifo_space = (cyc < spaceLow) ? 10'd10 : 10'd16;
            if (!active && pendAddr.size() > 0) begin
                sbAddr = pendAddr.pop_front();
                sbLen  = pendLen.pop_front();
                sbBeat = 0;
                active = 1;
            end
            rvalid  = active;
            rdata   = active ? {8{sbAddr + 64'(64 * sbBeat)}} : '0;
            rlast   = active && (sbBeat == sbLen);
            rresp   = (active && gBeat == errBeat) ? 2'b10 : 2'b00;
            arready = arvalid && (arWait >= arStall);
            #1;
            if (prevPend)
                checkOutput("ar_stable", 64'({arvalid, araddr[47:0], arlen}), 64'(prevAr));
            if (desc_rd_en) begin
                rdEnCount++;
                rdEnCyc        = cyc;
                desc_go        = 1'b0;
                desc_not_empty = 1'b0;
            end
            if (rd_fsm_done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (arvalid) begin
                if (firstArCyc < 0) firstArCyc = cyc;
                if (arready) begin
                    arAddrLog.push_back(araddr);
                    arLenLog.push_back(int'(arlen));
                    pendAddr.push_back(araddr);
                    pendLen.push_back(int'(arlen));
                    arSizeSeen  = arsize;
                    arBurstSeen = arburst;
                    arWait      = 0;
                    prevPend    = 0;
                end else begin
                    arWait++;
                    prevPend = 1;
                    prevAr   = {arvalid, araddr[47:0], arlen};
                end
            end else begin
                prevPend = 0;
            end
            if (fifo_wr_en) pushLog.push_back(lanes(fifo_wr_data));
            if (rvalid && rready) begin
                gBeat++;
                sbBeat++;
                if (rlast) active = 0;
            end
            if (doneCount > 0 || rd_state == 6'b100000 ||
                (stopPushes > 0 && pushLog.size() >= stopPushes)) begin
                finished = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!finished) checkOutput("timeout", 64'd0, 64'd1);
        if (stopPushes == 0) begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (rd_fsm_done) doneCount++;
            end
        end
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_state", 64'(rd_state), 64'h01);
        checkOutput("rst_ctrl", 64'({arvalid, rready, desc_rd_en, fifo_wr_en, rd_fsm_done,
                                     busy, stopped_on_error, rd_rsp_err}), 64'h0);
        checkOutput("rst_ar", 64'({araddr[31:0], arlen, arsize, arburst}), 64'h0);
        checkOutput("rst_cnt", {clk_cnt, valid_cnt}, 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single beat at 0x1000
        applyStimulus(64'h1000, 1, -1, 0, 0, 0);
        checkOutput("len1_ar_count", 64'(arAddrLog.size()), 64'd1);
        if (arAddrLog.size() == 1) begin
            checkOutput("len1_araddr", arAddrLog[0], 64'h1000);
            checkOutput("len1_arlen", 64'(arLenLog[0]), 64'd0);
        end
        checkOutput("len1_arsize", 64'(arSizeSeen), 64'd6);
        checkOutput("len1_arburst", 64'(arBurstSeen), 64'd1);
        checkOutput("len1_pushes", 64'(pushLog.size()), 64'd1);
        if (pushLog.size() == 1) checkOutput("len1_data", pushLog[0], 64'h1000);
        checkOutput("len1_done", 64'(doneCount), 64'd1);
        checkOutput("len1_rd_en", 64'(rdEnCount), 64'd1);
        checkOutput("len1_valid_cnt", 64'(valid_cnt), 64'd1);
        checkOutput("len1_clk_cnt", 64'(clk_cnt), 64'd4);
        checkOutput("len1_busy", 64'(busy), 64'd0);

        // 40 beats from 0 with a stalled AR channel: three bursts
        applyStimulus(64'h0, 40, -1, 0, 2, 0);
        checkOutput("len40_ar_count", 64'(arAddrLog.size()), 64'd3);
        if (arAddrLog.size() == 3) begin
            checkOutput("len40_ar0", {arAddrLog[0][55:0], 8'(arLenLog[0])}, {56'h0, 8'd15});
            checkOutput("len40_ar1", {arAddrLog[1][55:0], 8'(arLenLog[1])}, {56'h400, 8'd15});
            checkOutput("len40_ar2", {arAddrLog[2][55:0], 8'(arLenLog[2])}, {56'h800, 8'd7});
        end
        checkOutput("len40_pushes", 64'(pushLog.size()), 64'd40);
        for (int k = 0; k < pushLog.size() && k < 40; k++)
            checkOutput("len40_data", pushLog[k], 64'(64 * k));
        checkOutput("len40_done", 64'(doneCount), 64'd1);
        checkOutput("len40_valid_cnt", 64'(valid_cnt), 64'd40);

        // Zero-length descriptor
        applyStimulus(64'h2000, 0, -1, 0, 0, 0);
        checkOutput("len0_rd_en", 64'(rdEnCount), 64'd1);
        checkOutput("len0_no_ar", 64'(arAddrLog.size()), 64'd0);
        checkOutput("len0_no_push", 64'(pushLog.size()), 64'd0);
        checkOutput("len0_done", 64'(doneCount), 64'd1);
        checkOutput("len0_done_lag", 64'(doneCyc - rdEnCyc), 64'd1);

        // FIFO credit wait: space 10 for 20 cycles then 16
        applyStimulus(64'h4000, 16, -1, 20, 0, 0);
        checkOutput("space_first_ar", 64'(firstArCyc), 64'd21);
        checkOutput("space_pushes", 64'(pushLog.size()), 64'd16);
        checkOutput("space_done", 64'(doneCount), 64'd1);

        // SLVERR on the third beat
        applyStimulus(64'h8000, 16, 2, 0, 0, 0);
        checkOutput("err_state", 64'(rd_state), 64'h20);
        checkOutput("err_status", 64'({stopped_on_error, rd_rsp_err, rready}), 64'b110);
        checkOutput("err_pushes", 64'(pushLog.size()), 64'd3);
        checkOutput("err_valid_cnt", 64'(valid_cnt), 64'd3);
        checkOutput("err_no_done", 64'(doneCount), 64'd0);
        csr_reset_disp = 1'b1;
        @(posedge clk); #1;
        csr_reset_disp = 1'b0;
        checkOutput("err_clear_state", 64'(rd_state), 64'h01);
        checkOutput("err_clear_status", 64'({stopped_on_error, rd_rsp_err, busy}), 64'd0);

        // Reset during the data phase, at the fifth beat
        applyStimulus(64'hC000, 16, -1, 0, 0, 5);
        checkOutput("mid_pushes", 64'(pushLog.size()), 64'd5);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_ctrl", 64'({arvalid, rready, fifo_wr_en, busy}), 64'd0);
        checkOutput("mid_rst_state", 64'(rd_state), 64'h01);
        rvalid  = 1'b0;
        rlast   = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
